// File: rtl/aes_key_pkg.sv
// Shared constants, types and helpers for the AES key-expansion sequencer.
//   key_len_e    : Key_Len encodings (128/192/256, 3 reserved)
//   NK_*         : key length in 32-bit words
//   TOTAL_WORDS_*: words in the full schedule
//   SCRATCH_ADDR : register-file word written when no key word is produced
//   state_e      : sequencer FSM states
//   xtime        : GF(2^8) multiply-by-x, used for rcon and the S-box
package aes_key_pkg;

    typedef enum logic [1:0] {
        KeyLen128  = 2'd0,
        KeyLen192  = 2'd1,
        KeyLen256  = 2'd2,
        KeyLenRsvd = 2'd3
    } key_len_e;

    localparam logic [5:0] NK_128 = 6'd4;
    localparam logic [5:0] NK_192 = 6'd6;
    localparam logic [5:0] NK_256 = 6'd8;

    localparam logic [5:0] TOTAL_WORDS_128 = 6'd44;
    localparam logic [5:0] TOTAL_WORDS_192 = 6'd52;
    localparam logic [5:0] TOTAL_WORDS_256 = 6'd60;

    localparam logic [5:0] SCRATCH_ADDR = 6'd63;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StExpand,
        StDone
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for one byte.
//   data_i : input byte
//   data_o : S-box substituted byte
// Computed as multiplicative inverse in GF(2^8) (x^254) followed by the AES
// affine transform, instead of a 256-entry table.
module aes_sbox
    import aes_key_pkg::*;
(
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

    always_comb begin
        // Addition chain for x^254; 0 maps to 0 as required.
        x2   = gf_mul(data_i, data_i);
        x3   = gf_mul(x2, data_i);
        x6   = gf_mul(x3, x3);
        x7   = gf_mul(x6, data_i);
        x14  = gf_mul(x7, x7);
        x15  = gf_mul(x14, data_i);
        x30  = gf_mul(x15, x15);
        x31  = gf_mul(x30, data_i);
        x62  = gf_mul(x31, x31);
        x63  = gf_mul(x62, data_i);
        x126 = gf_mul(x63, x63);
        x127 = gf_mul(x126, data_i);
        inv  = gf_mul(x127, x127);
        data_o = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;
    end

endmodule

// File: rtl/key_expansion_ctrl.sv
// AES key-schedule sequencer/datapath feeding a 64x32 register file.
// Writes the Nk cipher-key words, then one expanded word per clock.
//   Clk, Rst              : clock, synchronous active-high reset
//   Start, Key_Len, Key_In: expansion request, sampled in IDLE only
//   Rd_Data_A / Rd_Data_B : register-file read data, w[i-1] / w[i-Nk]
//   Wr_Addr, Wr_Data      : register-file write port (writes every edge)
//   Rd_Addr_A, Rd_Addr_B  : register-file read addresses
//   Busy, Done, Num_Rounds: status
module key_expansion_ctrl
    import aes_key_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [1:0]   Key_Len,
    input  logic [255:0] Key_In,
    input  logic [31:0]  Rd_Data_A,
    input  logic [31:0]  Rd_Data_B,
    output logic [5:0]   Wr_Addr,
    output logic [31:0]  Wr_Data,
    output logic [5:0]   Rd_Addr_A,
    output logic [5:0]   Rd_Addr_B,
    output logic         Busy,
    output logic         Done,
    output logic [3:0]   Num_Rounds
);

    state_e         state_q, state_d;
    logic [5:0]     idx_q, idx_d;
    logic [5:0]     mod_q, mod_d;      // i mod Nk, wraps instead of dividing
    logic [255:0]   key_sr_q, key_sr_d;
    key_len_e       key_len_q, key_len_d;
    logic [3:0]     num_rounds_q, num_rounds_d;
    logic [7:0]     rcon_q, rcon_d;

    logic [5:0]     nk, total;
    logic [31:0]    sub_in, sub_out, temp;

    always_comb begin
        case (key_len_q)
            KeyLen192: begin nk = NK_192; total = TOTAL_WORDS_192; end
            KeyLen256: begin nk = NK_256; total = TOTAL_WORDS_256; end
            default:   begin nk = NK_128; total = TOTAL_WORDS_128; end
        endcase
    end

    // RotWord only on the i mod Nk = 0 words.
    assign sub_in = (mod_q == '0) ? {Rd_Data_A[23:0], Rd_Data_A[31:24]} : Rd_Data_A;

    for (genvar g = 0; g < 4; g++) begin : gen_sbox
        aes_sbox u_sbox (
            .data_i (sub_in[8*g +: 8]),
            .data_o (sub_out[8*g +: 8])
        );
    end

    always_comb begin
        if (mod_q == '0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (key_len_q == KeyLen256 && mod_q == 6'd4) begin
            temp = sub_out;
        end else begin
            temp = Rd_Data_A;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        mod_d        = mod_q;
        key_sr_d     = key_sr_q;
        key_len_d    = key_len_q;
        num_rounds_d = num_rounds_q;
        rcon_d       = rcon_q;
        Wr_Addr      = SCRATCH_ADDR;
        Wr_Data      = '0;
        Rd_Addr_A    = '0;
        Rd_Addr_B    = '0;
        Busy         = 1'b0;
        Done         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Start && Key_Len != KeyLenRsvd) begin
                    key_sr_d  = Key_In;
                    key_len_d = key_len_e'(Key_Len);
                    case (Key_Len)
                        2'd0:    num_rounds_d = 4'd10;
                        2'd1:    num_rounds_d = 4'd12;
                        default: num_rounds_d = 4'd14;
                    endcase
                    rcon_d  = 8'h01;
                    idx_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                Busy     = 1'b1;
                Wr_Addr  = idx_q;
                Wr_Data  = key_sr_q[255:224];
                key_sr_d = {key_sr_q[223:0], 32'h0};
                idx_d    = idx_q + 6'd1;
                if (idx_q == nk - 6'd1) begin
                    mod_d   = '0;
                    state_d = StExpand;
                end
            end
            StExpand: begin
                Busy      = 1'b1;
                Rd_Addr_A = idx_q - 6'd1;
                Rd_Addr_B = idx_q - nk;
                Wr_Addr   = idx_q;
                Wr_Data   = temp ^ Rd_Data_B;
                idx_d     = idx_q + 6'd1;
                mod_d     = (mod_q == nk - 6'd1) ? '0 : mod_q + 6'd1;
                if (mod_q == '0) rcon_d = xtime(rcon_q);
                if (idx_q == total - 6'd1) state_d = StDone;
            end
            StDone: begin
                Done    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    assign Num_Rounds = num_rounds_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            mod_q        <= '0;
            key_sr_q     <= '0;
            key_len_q    <= KeyLen128;
            num_rounds_q <= '0;
            rcon_q       <= 8'h01;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mod_q        <= mod_d;
            key_sr_q     <= key_sr_d;
            key_len_q    <= key_len_d;
            num_rounds_q <= num_rounds_d;
            rcon_q       <= rcon_d;
        end
    end

endmodule
